topview_sched: RTL and testbench

Round-robin scheduler that shares one top-view perspective-transform unit among several requesters (lane detector, obstacle detector, …). It accepts bounding boxes in camera-image coordinates and range-checks them. Each legal box is issued to the transform unit, the scheduler waits for the unit's `valid` under a timeout, and the transformed top-view box is returned tagged with the requester ID. It sits between the detection stages and the top-view transform instance.

---
 rtl/topview_sched.sv | 135 +++++++++++++
 tb/tb_topview_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/topview_sched.sv
// topview_sched: round-robin sharing of one top-view transform unit with box range checks and timeout
module topview_sched #(
  parameter int NREQ = 2,
  parameter int IN_WIDTH = 640,
  parameter int IN_HEIGHT = 480,
  parameter int OUT_BITW = 32,
  parameter int TIMEOUT = 64,
  localparam int VW = $clog2(IN_HEIGHT) + 1,
  localparam int HW = $clog2(IN_WIDTH) + 1,
  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*VW-1:0]         req_start_v,
  input  logic [NREQ*VW-1:0]         req_end_v,
  input  logic [NREQ*HW-1:0]         req_start_h,
  input  logic [NREQ*HW-1:0]         req_end_h,
  output logic [VW-1:0]              tv_start_v,
  output logic [VW-1:0]              tv_end_v,
  output logic [HW-1:0]              tv_start_h,
  output logic [HW-1:0]              tv_end_h,
  output logic                       tv_start,
  input  logic                       tv_valid,
  input  logic signed [OUT_BITW-1:0] tv_out_start_v,
  input  logic signed [OUT_BITW-1:0] tv_out_end_v,
  input  logic signed [OUT_BITW-1:0] tv_out_start_h,
  input  logic signed [OUT_BITW-1:0] tv_out_end_h,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic                       rsp_err,
  output logic signed [OUT_BITW-1:0] rsp_start_v,
  output logic signed [OUT_BITW-1:0] rsp_end_v,
  output logic signed [OUT_BITW-1:0] rsp_start_h,
  output logic signed [OUT_BITW-1:0] rsp_end_h
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] rr, gid, j;
  logic found, legal, timeout;
  logic [CW-1:0] cnt;
  logic [VW-1:0] sv_a [NREQ];
  logic [VW-1:0] ev_a [NREQ];
  logic [HW-1:0] sh_a [NREQ];
  logic [HW-1:0] eh_a [NREQ];
  logic [VW-1:0] m_sv, m_ev;
  logic [HW-1:0] m_sh, m_eh;
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign sv_a[g] = req_start_v[g*VW +: VW];
    assign ev_a[g] = req_end_v[g*VW +: VW];
    assign sh_a[g] = req_start_h[g*HW +: HW];
    assign eh_a[g] = req_end_h[g*HW +: HW];
  end
  always_comb begin
    found = 1'b0;
    gid = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IDW'((int'(rr) + k) % NREQ);
      if (req_valid[j]) begin
        found = 1'b1;
        gid = j;
      end
    end
  end
  assign m_sv = sv_a[gid];
  assign m_ev = ev_a[gid];
  assign m_sh = sh_a[gid];
  assign m_eh = eh_a[gid];
  assign legal = (m_sv <= m_ev) && (m_sh <= m_eh) && (m_ev < VW'(IN_HEIGHT)) && (m_eh < HW'(IN_WIDTH));
  assign timeout = cnt == CW'(TIMEOUT - 1);
  assign req_ready = (state == IDLE && found) ? NREQ'(1) << gid : '0;
  assign tv_start = state == ISSUE;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk)
    state <= !n_rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = found ? (legal ? ISSUE : RESP) : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (tv_valid || timeout) ? RESP : WAIT;
      default: state_nx = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rr <= '0;
      rsp_id <= '0;
      cnt <= '0;
      rsp_err <= 1'b0;
      tv_start_v <= '0;
      tv_end_v <= '0;
      tv_start_h <= '0;
      tv_end_h <= '0;
      rsp_start_v <= '0;
      rsp_end_v <= '0;
      rsp_start_h <= '0;
      rsp_end_h <= '0;
    end else begin
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      if (state == IDLE && found) begin
        rr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
        rsp_id <= gid;
        tv_start_v <= m_sv;
        tv_end_v <= m_ev;
        tv_start_h <= m_sh;
        tv_end_h <= m_eh;
        rsp_err <= !legal;
        if (!legal) begin
          rsp_start_v <= '0;
          rsp_end_v <= '0;
          rsp_start_h <= '0;
          rsp_end_h <= '0;
        end
      end
      if (state == WAIT && tv_valid) begin
        rsp_err <= 1'b0;
        rsp_start_v <= tv_out_start_v;
        rsp_end_v <= tv_out_end_v;
        rsp_start_h <= tv_out_start_h;
        rsp_end_h <= tv_out_end_h;
      end else if (state == WAIT && timeout) begin
        rsp_err <= 1'b1;
        rsp_start_v <= '0;
        rsp_end_v <= '0;
        rsp_start_h <= '0;
        rsp_end_h <= '0;
      end
    end
  end
endmodule

// File: tb/tb_topview_sched.sv
// tb_topview_sched: directed self-checking bench for topview_sched
module tb_topview_sched;
  localparam int VW = 10;
  localparam int HW = 11;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [2*VW-1:0] req_start_v = '0, req_end_v = '0;
  logic [2*HW-1:0] req_start_h = '0, req_end_h = '0;
  logic [VW-1:0] tv_start_v, tv_end_v;
  logic [HW-1:0] tv_start_h, tv_end_h;
  logic tv_start;
  logic tv_valid = 1'b0;
  logic signed [31:0] tv_out_start_v = '0, tv_out_end_v = '0, tv_out_start_h = '0, tv_out_end_h = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic rsp_id;
  logic rsp_err;
  logic signed [31:0] rsp_start_v, rsp_end_v, rsp_start_h, rsp_end_h;
  int n_cmp = 0;
  int n_bad = 0;

  topview_sched dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_start_v(req_start_v), .req_end_v(req_end_v),
    .req_start_h(req_start_h), .req_end_h(req_end_h),
    .tv_start_v(tv_start_v), .tv_end_v(tv_end_v),
    .tv_start_h(tv_start_h), .tv_end_h(tv_end_h),
    .tv_start(tv_start), .tv_valid(tv_valid),
    .tv_out_start_v(tv_out_start_v), .tv_out_end_v(tv_out_end_v),
    .tv_out_start_h(tv_out_start_h), .tv_out_end_h(tv_out_end_h),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_start_v(rsp_start_v), .rsp_end_v(rsp_end_v),
    .rsp_start_h(rsp_start_h), .rsp_end_h(rsp_end_h)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    n_cmp++;
    if (!$onehot0(req_ready) || (req_ready != 2'b00 && (tv_start || rsp_valid))) begin
      n_bad++;
      $display("FAIL ready_monitor: req_ready=%b tv_start=%b rsp_valid=%b", req_ready, tv_start, rsp_valid);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_box(input int i, input int sv, input int ev, input int sh, input int eh);
    req_start_v[i*VW +: VW] = VW'(sv);
    req_end_v[i*VW +: VW] = VW'(ev);
    req_start_h[i*HW +: HW] = HW'(sh);
    req_end_h[i*HW +: HW] = HW'(eh);
  endtask

  task automatic set_tv(input int a, input int b, input int c, input int d);
    tv_valid = 1'b1;
    tv_out_start_v = a;
    tv_out_end_v = b;
    tv_out_start_h = c;
    tv_out_end_h = d;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    tick;
    tick;
    n_cmp++;
    if ({req_ready, tv_start, rsp_valid, rsp_err, rsp_id} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {req_ready, tv_start, rsp_valid, rsp_err, rsp_id});
    end
    n_cmp++;
    if ({tv_start_v, tv_end_v, tv_start_h, tv_end_h} !== '0 || {rsp_start_v, rsp_end_v, rsp_start_h, rsp_end_h} !== '0) begin
      n_bad++;
      $display("FAIL reset_coords: tv=%0d/%0d rsp=%0d/%0d want 0", tv_start_v, tv_end_h, rsp_start_v, rsp_end_h);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_round_robin;
    rsp_ready = 1'b1;
    set_box(0, 1, 2, 3, 50);
    set_box(1, 4, 5, 6, 60);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (req_ready !== 2'(1 << (i % 2))) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, 2'(1 << (i % 2)));
      end
      tick;
      n_cmp++;
      if (tv_start !== 1'b1 || tv_end_h !== HW'((i % 2) ? 60 : 50)) begin
        n_bad++;
        $display("FAIL rr_issue%0d: tv_start=%b tv_end_h=%0d want 1/%0d", i, tv_start, tv_end_h, (i % 2) ? 60 : 50);
      end
      tick;
      set_tv(i, 0, 0, 0);
      tick;
      tv_valid = 1'b0;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2) || rsp_start_v !== i || rsp_err !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_rsp%0d: valid=%b id=%0d sv=%0d err=%b want 1/%0d/%0d/0", i, rsp_valid, rsp_id, rsp_start_v, rsp_err, i % 2, i);
      end
      tick;
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
  endtask

  task automatic test_legal;
    set_box(0, 0, 479, 100, 200);
    req_valid = 2'b01;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++;
      $display("FAIL legal_grant: got %b want 01", req_ready);
    end
    for (int k = 1; k <= 7; k++) begin
      tick;
      if (k == 1) begin
        req_valid = 2'b00;
        n_cmp++;
        if (tv_start !== 1'b1 || tv_start_v !== 10'd0 || tv_end_v !== 10'd479 || tv_start_h !== 11'd100 || tv_end_h !== 11'd200) begin
          n_bad++;
          $display("FAIL legal_issue: tv_start=%b box=%0d,%0d,%0d,%0d want 1 0,479,100,200", tv_start, tv_start_v, tv_end_v, tv_start_h, tv_end_h);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if (tv_start !== 1'b0 || tv_end_v !== 10'd479) begin
          n_bad++;
          $display("FAIL legal_pulse: tv_start=%b tv_end_v=%0d want 0/479", tv_start, tv_end_v);
        end
      end
      if (k == 6) begin
        set_tv(-20, 30, 5, 90);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL legal_early: rsp_valid=%b want 0", rsp_valid);
        end
      end
      if (k == 7) begin
        tv_valid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b0 || rsp_start_v !== -20 || rsp_end_v !== 30 || rsp_start_h !== 5 || rsp_end_h !== 90) begin
          n_bad++;
          $display("FAIL legal_rsp: v=%b id=%0d err=%b box=%0d,%0d,%0d,%0d want 1 0 0 -20,30,5,90", rsp_valid, rsp_id, rsp_err, rsp_start_v, rsp_end_v, rsp_start_h, rsp_end_h);
        end
      end
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL legal_done: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_timeout;
    set_box(0, 10, 20, 30, 40);
    req_valid = 2'b01;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++;
      $display("FAIL to_grant: got %b want 01", req_ready);
    end
    for (int k = 1; k <= 66; k++) begin
      tick;
      if (k == 1) req_valid = 2'b00;
      if (k == 65) begin
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL to_early: rsp_valid=%b want 0 at T+65", rsp_valid);
        end
      end
    end
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_id !== 1'b0 || {rsp_start_v, rsp_end_v, rsp_start_h, rsp_end_h} !== '0) begin
      n_bad++;
      $display("FAIL to_rsp: v=%b err=%b id=%0d box=%0d,%0d,%0d,%0d want 1 1 0 zeros", rsp_valid, rsp_err, rsp_id, rsp_start_v, rsp_end_v, rsp_start_h, rsp_end_h);
    end
    tick;
    set_tv(1, 2, 3, 4);
    tick;
    tv_valid = 1'b0;
    tick;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_start_v !== 0 || rsp_end_h !== 0) begin
      n_bad++;
      $display("FAIL to_late_valid: v=%b err=%b sv=%0d eh=%0d want 1 1 0 0", rsp_valid, rsp_err, rsp_start_v, rsp_end_h);
    end
    rsp_ready = 1'b1;
    tick;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL to_done: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_illegal;
    rsp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) set_box(1, 10, 20, 300, 100);
      else set_box(0, 0, 480, 0, 10);
      req_valid = (t == 0) ? 2'b10 : 2'b01;
      #1;
      n_cmp++;
      if (req_ready !== req_valid) begin
        n_bad++;
        $display("FAIL ill_grant%0d: got %b want %b", t, req_ready, req_valid);
      end
      tick;
      req_valid = 2'b00;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_id !== 1'(1 - t) || tv_start !== 1'b0 || {rsp_start_v, rsp_end_v, rsp_start_h, rsp_end_h} !== '0) begin
        n_bad++;
        $display("FAIL ill_rsp%0d: v=%b err=%b id=%0d tv_start=%b sv=%0d want 1 1 %0d 0 0", t, rsp_valid, rsp_err, rsp_id, tv_start, rsp_start_v, 1 - t);
      end
      tick;
      n_cmp++;
      if (tv_start !== 1'b0 || rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL ill_after%0d: tv_start=%b rsp_valid=%b want 0 0", t, tv_start, rsp_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    set_box(0, 5, 6, 7, 8);
    set_box(1, 5, 6, 7, 8);
    req_valid = 2'b01;
    #1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      if (k == 1) req_valid = 2'b00;
      if (k == 3) set_tv(7, -8, 9, -10);
    end
    tv_valid = 1'b0;
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_start_v !== 7 || rsp_end_v !== -8 || rsp_start_h !== 9 || rsp_end_h !== -10 || req_ready !== 2'b00) begin
        n_bad++;
        $display("FAIL bp_hold%0d: v=%b box=%0d,%0d,%0d,%0d ready=%b want 1 7,-8,9,-10 00", c, rsp_valid, rsp_start_v, rsp_end_v, rsp_start_h, rsp_end_h, req_ready);
      end
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b want 0 10", rsp_valid, req_ready);
    end
    req_valid = 2'b00;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_bad++;
      $display("FAIL bp_drop: req_ready=%b want 00", req_ready);
    end
  endtask

  task automatic test_reset_mid;
    set_box(0, 1, 2, 3, 4);
    set_box(1, 11, 22, 33, 44);
    req_valid = 2'b01;
    #1;
    tick;
    req_valid = 2'b00;
    tick;
    tick;
    n_rst = 1'b0;
    tick;
    n_cmp++;
    if ({req_ready, tv_start, rsp_valid, rsp_err, rsp_id} !== 6'b0 || {tv_start_v, tv_end_v, tv_start_h, tv_end_h} !== '0 || {rsp_start_v, rsp_end_v, rsp_start_h, rsp_end_h} !== '0) begin
      n_bad++;
      $display("FAIL midrst_out: ctrl=%b tv_ev=%0d rsp_sv=%0d rsp_eh=%0d want zeros", {req_ready, tv_start, rsp_valid, rsp_err, rsp_id}, tv_end_v, rsp_start_v, rsp_end_h);
    end
    n_rst = 1'b1;
    set_tv(5, 5, 5, 5);
    tick;
    tv_valid = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || tv_start !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_late: rsp_valid=%b tv_start=%b want 0 0", rsp_valid, tv_start);
    end
    req_valid = 2'b11;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++;
      $display("FAIL midrst_rr: req_ready=%b want 01", req_ready);
    end
    req_valid = 2'b10;
    #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_bad++;
      $display("FAIL midrst_req1: req_ready=%b want 10", req_ready);
    end
    tick;
    req_valid = 2'b00;
    n_cmp++;
    if (tv_start !== 1'b1 || tv_start_v !== 10'd11 || tv_end_h !== 11'd44) begin
      n_bad++;
      $display("FAIL midrst_issue: tv_start=%b sv=%0d eh=%0d want 1 11 44", tv_start, tv_start_v, tv_end_h);
    end
    n_rst = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_legal;
    test_timeout;
    test_illegal;
    test_backpressure;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
